flash_read_responder: RTL and testbench
=======================================

FLASH_READ_RESPONDER -- requirements
Module: flash_read_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the number of cycles byte_rd may stay high without byte_ack before the lane is abandoned; legal range 1..255.
REQ-002 SHALL have port clock  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port mem_read  input  1  word read request from the initiator.
REQ-005 SHALL have port address  input  23  word address of the request.
REQ-006 SHALL have port byteenable  input  4  lanes requested; bit n maps to readdata[8n+7:8n].
REQ-007 SHALL have port waitrequest  output  1  high = request not accepted this cycle.
REQ-008 SHALL have port readdata  output  32  response word.
REQ-009 SHALL have port readdatavalid  output  1  one-cycle pulse qualifying readdata.
REQ-010 SHALL have port byte_addr  output  25  backing byte address = {address, lane[1:0]}.
REQ-011 SHALL have port byte_rd  output  1  backing byte read strobe, held until byte_ack.
REQ-012 SHALL have port byte_ack  input  1  backing byte data valid this cycle.
REQ-013 SHALL have port byte_data  input  8  backing byte.
REQ-014 SHALL have port clear_err  input  1  synchronous clear of err.
REQ-015 SHALL have port err  output  1  sticky flag meaning at least one lane timed out.

Function
REQ-016 SHALL implement the states IDLE, FETCH, NEXT and RESP.
REQ-017 SHALL drive waitrequest low only in IDLE; a request is accepted when mem_read=1 in IDLE, latching address and byteenable.
REQ-018 SHALL, on accept, go to FETCH on the lowest enabled lane, or to RESP directly when byteenable=0000.
REQ-019 SHALL in FETCH hold byte_rd=1 and byte_addr stable; on byte_ack, store byte_data into the lane and go to NEXT, or to RESP if no higher enabled lane remains.
REQ-020 SHALL in NEXT hold byte_rd=0 for exactly one cycle, then enter FETCH on the next higher enabled lane; disabled lanes are skipped in zero cycles.
REQ-021 SHALL return 0x00 in disabled lanes; no backing access is made for them.
REQ-022 SHALL count FETCH cycles without ack; at count TIMEOUT_CYCLES the lane gets 0xFF, err sets, and the FSM proceeds as if acked.
REQ-023 SHALL give byte_ack priority when byte_ack and the timeout terminal count occur in the same cycle; the lane then takes byte_data and err is unchanged.
REQ-024 SHALL, in RESP, pulse readdatavalid for one cycle with the assembled readdata, then return to IDLE; readdata holds until the next RESP.
REQ-025 SHALL meet a latency of 8 cycles from the accept cycle to readdatavalid for byteenable=1111 with byte_ack in every first FETCH cycle; byteenable=0000 gives 1 cycle.
REQ-026 SHALL ignore mem_read outside IDLE; a request held across busy cycles is accepted on the IDLE cycle.
REQ-027 SHALL let clear_err clear err next cycle; a same-cycle timeout wins and sets err.

Reset
REQ-028 SHALL on reset=0, asynchronously: state to IDLE; waitrequest, readdatavalid, byte_rd and err to 0; readdata and byte_addr to 0; timeout counter to 0.
REQ-029 SHALL abandon any transaction in flight when reset occurs mid-transaction; no readdatavalid is produced for it after release.

Configuration
REQ-030 SHALL, with FLASH_RESP_CACHE_EN defined, hold a one-word cache (tag, data, valid) filled only when all four lanes complete without timeout.
REQ-031 SHALL, with FLASH_RESP_CACHE_EN defined, treat an accepted request as a hit when valid=1 and tag=address: go to RESP next cycle, with no byte_rd, enabled lanes from cache, disabled lanes 0x00.
REQ-032 SHALL, with FLASH_RESP_CACHE_EN defined, clear cache valid on reset, on any timeout and on clear_err.
REQ-033 SHALL, without FLASH_RESP_CACHE_EN, contain no cache logic; every request fetches from the backing interface as in Function.

Verification
REQ-034 SHALL cover: read addr 0x000010, be=1111, backing bytes 11,22,33,44 acked immediately -> byte_addr 0x40..0x43, readdata=0x44332211, readdatavalid 8 cycles after accept.
REQ-035 SHALL cover: be=0101, bytes AA,CC -> only byte_addr lanes 0 and 2 accessed, readdata=0x00CC00AA.
REQ-036 SHALL cover: TIMEOUT_CYCLES=4, lane 1 never acked -> byte_rd high 4 cycles, readdata[15:8]=0xFF, err=1 until clear_err pulse.
REQ-037 SHALL cover: reset pulsed during FETCH of lane 2 -> byte_rd=0 immediately, no readdatavalid, next request served normally.
REQ-038 SHALL cover: with FLASH_RESP_CACHE_EN, two reads of 0x000010 be=1111 -> second has no byte_rd, readdatavalid 1 cycle after accept, same data.
REQ-039 SHALL cover: byte_ack coincident with timeout terminal count, byte_data=0x5A -> lane=0x5A, err stays 0.

Source files
------------

// File: rtl/flash_read_responder.sv
// flash_read_responder: answers 32-bit word reads by fetching each enabled
// byte lane, lowest lane first, from an 8-bit backing interface. A lane that
// is not acked within TIMEOUT_CYCLES returns 0xFF and sets the sticky err flag.
// Optional build macro FLASH_RESP_CACHE_EN adds a one-word read cache.
module flash_read_responder #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read,
    input  logic [22:0] address,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic [24:0] byte_addr,
    output logic        byte_rd,
    input  logic        byte_ack,
    input  logic [7:0]  byte_data,
    input  logic        clear_err,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, FETCH, NEXT, RESP} state_t;

    // Terminal count: the TIMEOUT_CYCLES-th unacked FETCH cycle.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [22:0] addr_q;
    logic [3:0]  be_q;
    logic [1:0]  lane;
    logic [7:0]  tmo_cnt;
    logic [31:0] data_buf;
    logic        tmo_hit;
    logic        lane_done;
    logic [7:0]  lane_byte;
    logic [31:0] merged;
    logic [2:0]  first_lane;
    logic [2:0]  next_lane;

    // Lowest enabled lane at or above 'from'; bit 2 flags that one was found.
    function automatic logic [2:0] find_lane(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= from)) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    // An ack in the terminal cycle wins over the timeout.
    assign tmo_hit    = (state == FETCH) && !byte_ack && (tmo_cnt == TMO_LAST);
    assign lane_done  = (state == FETCH) && (byte_ack || tmo_hit);
    assign lane_byte  = byte_ack ? byte_data : 8'hFF;
    assign first_lane = find_lane(byteenable, 3'd0);
    assign next_lane  = find_lane(be_q, {1'b0, lane} + 3'd1);

    // Assembly buffer with the lane currently being completed merged in.
    always_comb begin
        merged = data_buf;
        merged[{lane, 3'b000} +: 8] = lane_byte;
    end

`ifdef FLASH_RESP_CACHE_EN
    logic [22:0] cache_tag;
    logic [31:0] cache_data;
    logic        cache_vld;
    logic        tmo_seen;
    logic        cache_hit;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    assign cache_hit = cache_vld && (cache_tag == address);

    // Cache fill on a clean four-lane fetch; invalidate on timeout or clear_err.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cache_vld  <= 1'b0;
            cache_tag  <= '0;
            cache_data <= '0;
            tmo_seen   <= 1'b0;
        end else begin
            if (state == IDLE && mem_read) tmo_seen <= 1'b0;
            else if (tmo_hit)              tmo_seen <= 1'b1;

            if (tmo_hit || clear_err) begin
                cache_vld <= 1'b0;
            end else if (lane_done && !next_lane[2] && be_q == 4'hF && !tmo_seen) begin
                cache_vld  <= 1'b1;
                cache_tag  <= addr_q;
                cache_data <= merged;
            end
        end
    end
`endif

    // Sticky error: a same-cycle timeout beats clear_err.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)         err <= 1'b0;
        else if (tmo_hit)   err <= 1'b1;
        else if (clear_err) err <= 1'b0;
    end

    // Transaction FSM with registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            waitrequest   <= 1'b0;
            readdatavalid <= 1'b0;
            readdata      <= '0;
            byte_addr     <= '0;
            byte_rd       <= 1'b0;
            tmo_cnt       <= '0;
            addr_q        <= '0;
            be_q          <= '0;
            lane          <= '0;
            data_buf      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    readdatavalid <= 1'b0;
                    if (mem_read) begin
                        addr_q      <= address;
                        be_q        <= byteenable;
                        data_buf    <= '0;
                        tmo_cnt     <= '0;
                        waitrequest <= 1'b1;
`ifdef FLASH_RESP_CACHE_EN
                        if (cache_hit) begin
                            readdata      <= cache_data & lane_mask(byteenable);
                            readdatavalid <= 1'b1;
                            state         <= RESP;
                        end else
`endif
                        if (first_lane[2]) begin
                            lane      <= first_lane[1:0];
                            byte_addr <= {address, first_lane[1:0]};
                            byte_rd   <= 1'b1;
                            state     <= FETCH;
                        end else begin
                            readdata      <= '0;
                            readdatavalid <= 1'b1;
                            state         <= RESP;
                        end
                    end
                end
                FETCH: begin
                    if (lane_done) begin
                        data_buf <= merged;
                        byte_rd  <= 1'b0;
                        tmo_cnt  <= '0;
                        if (next_lane[2]) begin
                            lane  <= next_lane[1:0];
                            state <= NEXT;
                        end else begin
                            readdata      <= merged;
                            readdatavalid <= 1'b1;
                            state         <= RESP;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                NEXT: begin
                    byte_addr <= {addr_q, lane};
                    byte_rd   <= 1'b1;
                    state     <= FETCH;
                end
                RESP: begin
                    readdatavalid <= 1'b0;
                    waitrequest   <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_read_responder.sv
// Directed bench for flash_read_responder (TIMEOUT_CYCLES = 4) with a
// behavioural backing-memory responder and a readdata scoreboard queue.
module tb_flash_read_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_read = 1'b0;
    logic [22:0] address = '0;
    logic [3:0]  byteenable = '0;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic [24:0] byte_addr;
    logic        byte_rd;
    logic        byte_ack = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        clear_err = 1'b0;
    logic        err;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // Responder configuration (written by the stimulus process only).
    logic [7:0] mem_bytes [4];
    int ack_delay  = 0;
    int never_lane = -1;

    // Responder bookkeeping (written by the responder process only).
    int acc_cnt [4];
    int rd_hi   [4];
    logic [24:0] addr_seen [4];
    int hold = 0;
    int ln   = 0;

    // Snapshots taken by the stimulus process.
    int snap_acc [4];
    int snap_rd  [4];

    flash_read_responder #(.TIMEOUT_CYCLES(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .mem_read     (mem_read),
        .address      (address),
        .byteenable   (byteenable),
        .waitrequest  (waitrequest),
        .readdata     (readdata),
        .readdatavalid(readdatavalid),
        .byte_addr    (byte_addr),
        .byte_rd      (byte_rd),
        .byte_ack     (byte_ack),
        .byte_data    (byte_data),
        .clear_err    (clear_err),
        .err          (err)
    );

    always #5 clock = ~clock;

    // Backing memory: acks after ack_delay cycles of byte_rd, never for never_lane.
    always @(negedge clock) begin
        if (byte_rd) begin
            ln = int'(byte_addr[1:0]);
            if (hold == 0) begin
                acc_cnt[ln]   = acc_cnt[ln] + 1;
                addr_seen[ln] = byte_addr;
            end
            rd_hi[ln] = rd_hi[ln] + 1;
            byte_ack  = (ln != never_lane) && (hold == ack_delay);
            byte_data = mem_bytes[ln];
            hold      = hold + 1;
        end else begin
            byte_ack = 1'b0;
            hold     = 0;
        end
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 4; i++) begin
            snap_acc[i] = acc_cnt[i];
            snap_rd[i]  = rd_hi[i];
        end
    endtask

    task automatic set_mem(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
        mem_bytes[0] = b0;
        mem_bytes[1] = b1;
        mem_bytes[2] = b2;
        mem_bytes[3] = b3;
    endtask

    // One read: push expectation, wait for accept, then for readdatavalid.
    task automatic do_read(input logic [22:0] a, input logic [3:0] be,
                           input logic [31:0] exp, input int exp_lat, input string tag);
        int n;
        logic got;
        logic [31:0] e;
        @(negedge clock);
        mem_read   = 1'b1;
        address    = a;
        byteenable = be;
        exp_q.push_back(exp);
        n = 0;
        while (waitrequest && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk(waitrequest, 1'b0, {tag, "_accept"});
        @(negedge clock);
        mem_read = 1'b0;
        n = 1;
        while (!readdatavalid && n < 100) begin
            @(negedge clock);
            n++;
        end
        got = readdatavalid;
        chk(got, 1'b1, {tag, "_rvld"});
        e = exp_q.pop_front();
        if (got) begin
            chk(readdata, e, {tag, "_data"});
            if (exp_lat > 0) chk(n, exp_lat, {tag, "_latency"});
            @(negedge clock);
            chk(readdatavalid, 1'b0, {tag, "_pulse"});
        end
    endtask

    initial begin
        int n;
        logic seen;

        // Reset state
        set_mem(8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clock);
        @(negedge clock);
        chk(waitrequest,   1'b0, "rst_waitrequest");
        chk(readdatavalid, 1'b0, "rst_readdatavalid");
        chk(byte_rd,       1'b0, "rst_byte_rd");
        chk(err,           1'b0, "rst_err");
        chk(readdata,      32'h0, "rst_readdata");
        chk(byte_addr,     25'h0, "rst_byte_addr");
        reset = 1'b1;
        @(negedge clock);

        // Full word, immediate acks
        set_mem(8'h11, 8'h22, 8'h33, 8'h44);
        ack_delay = 0;
        never_lane = -1;
        snap();
        do_read(23'h000010, 4'b1111, 32'h44332211, 8, "full");
        for (int i = 0; i < 4; i++) begin
            chk(addr_seen[i], {23'h000010, 2'(i)}, "full_byte_addr");
            chk(rd_hi[i] - snap_rd[i], 1, "full_rd_cycles");
        end
        chk(err, 1'b0, "full_err");

        // Sparse lanes 0 and 2
        set_mem(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        snap();
        do_read(23'h123456, 4'b0101, 32'h00CC00AA, 4, "sparse");
        chk(acc_cnt[0] - snap_acc[0], 1, "sparse_acc0");
        chk(acc_cnt[1] - snap_acc[1], 0, "sparse_acc1");
        chk(acc_cnt[2] - snap_acc[2], 1, "sparse_acc2");
        chk(acc_cnt[3] - snap_acc[3], 0, "sparse_acc3");
        chk(addr_seen[2], {23'h123456, 2'b10}, "sparse_addr2");

        // No lanes enabled
        snap();
        do_read(23'h000020, 4'b0000, 32'h0, 1, "empty");
        chk((acc_cnt[0] + acc_cnt[1] + acc_cnt[2] + acc_cnt[3])
            - (snap_acc[0] + snap_acc[1] + snap_acc[2] + snap_acc[3]), 0, "empty_acc");

        // Lane 1 times out
        set_mem(8'h01, 8'h02, 8'h03, 8'h04);
        never_lane = 1;
        snap();
        do_read(23'h000030, 4'b1111, 32'h0403FF01, 11, "timeout");
        chk(rd_hi[1] - snap_rd[1], 4, "timeout_rd_cycles");
        chk(err, 1'b1, "timeout_err_set");
        repeat (3) @(negedge clock);
        chk(err, 1'b1, "timeout_err_sticky");
        clear_err = 1'b1;
        @(negedge clock);
        clear_err = 1'b0;
        chk(err, 1'b0, "timeout_err_cleared");
        never_lane = -1;

        // Ack lands on the terminal count
        set_mem(8'h00, 8'h5A, 8'h00, 8'h00);
        ack_delay = 3;
        snap();
        do_read(23'h000040, 4'b0010, 32'h00005A00, 5, "coincide");
        chk(rd_hi[1] - snap_rd[1], 4, "coincide_rd_cycles");
        chk(err, 1'b0, "coincide_err");
        ack_delay = 0;

        // Reset during FETCH of lane 2
        set_mem(8'h10, 8'h20, 8'h30, 8'h40);
        never_lane = 2;
        @(negedge clock);
        mem_read   = 1'b1;
        address    = 23'h000055;
        byteenable = 4'b1111;
        @(negedge clock);
        mem_read = 1'b0;
        n = 0;
        while (!(byte_rd && byte_addr[1:0] == 2'd2) && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk(byte_rd && byte_addr[1:0] == 2'd2, 1'b1, "midrst_reach_lane2");
        #2 reset = 1'b0;
        #1;
        chk(byte_rd,     1'b0, "midrst_byte_rd");
        chk(waitrequest, 1'b0, "midrst_waitrequest");
        @(negedge clock);
        reset = 1'b1;
        never_lane = -1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (readdatavalid) seen = 1'b1;
        end
        chk(seen, 1'b0, "midrst_no_rvld");

        // Normal service after reset
        set_mem(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        do_read(23'h7FFFFF, 4'b1001, 32'hD40000A1, 4, "postrst");
        chk(addr_seen[3], 25'h1FFFFFF, "postrst_addr3");

`ifdef FLASH_RESP_CACHE_EN
        // Second read of the same word is served from the cache
        set_mem(8'h11, 8'h22, 8'h33, 8'h44);
        do_read(23'h000010, 4'b1111, 32'h44332211, 8, "cache_fill");
        snap();
        do_read(23'h000010, 4'b1111, 32'h44332211, 1, "cache_hit");
        chk((rd_hi[0] + rd_hi[1] + rd_hi[2] + rd_hi[3])
            - (snap_rd[0] + snap_rd[1] + snap_rd[2] + snap_rd[3]), 0, "cache_no_byte_rd");
`endif

        chk(exp_q.size(), 0, "scoreboard_empty");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
